// File: rtl/alu_exec.sv
// alu_exec: 32-bit execute-stage ALU with an iterative shift-add multiplier.
// Single-cycle ops return a result one cycle after accept. MUL runs 32 steps
// and returns its result 32 edges after the accepting edge. Result and
// out_valid form a valid/ready output register that holds under backpressure.
module alu_exec (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  Alu_Control,
  input  logic        S,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic [3:0]  Flags,
  output logic        busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b100;
  localparam logic [2:0] OP_EOR = 3'b101;
  localparam logic [2:0] OP_BIC = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] mcand_reg;
  logic [31:0] mplier_reg;
  logic [31:0] acc_reg;
  logic        s_reg;

  logic        is_sub;
  logic [31:0] b_op;
  logic [32:0] sum33;
  logic [31:0] alu_res;
  logic [3:0]  alu_flags;
  logic [31:0] acc_step;
  logic [3:0]  mul_flags;
  logic        accept;

  // Handshake: only accept when idle and the output register is free or draining.
  assign in_ready = (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_reg == MUL);

  // Single-cycle datapath: 33-bit add/subtract plus logic ops and flag generation.
  always_comb begin
    is_sub    = (Alu_Control == OP_SUB);
    b_op      = is_sub ? ~SrcB : SrcB;
    sum33     = {1'b0, SrcA} + {1'b0, b_op} + {32'd0, is_sub};
    alu_res   = sum33[31:0];
    alu_flags = Flags;
    case (Alu_Control)
      OP_ADD, OP_SUB: alu_res = sum33[31:0];
      OP_AND:         alu_res = SrcA & SrcB;
      OP_ORR:         alu_res = SrcA | SrcB;
      OP_MOV:         alu_res = SrcB;
      OP_EOR:         alu_res = SrcA ^ SrcB;
      OP_BIC:         alu_res = SrcA & ~SrcB;
      default:        alu_res = 32'd0;
    endcase
    if (S) begin
      alu_flags[3] = alu_res[31];
      alu_flags[2] = (alu_res == 32'd0);
      if ((Alu_Control == OP_ADD) || is_sub) begin
        // C is the raw carry out; for SUB that means "no borrow".
        alu_flags[1] = sum33[32];
        // Overflow when both addends share a sign that the sum does not.
        alu_flags[0] = (SrcA[31] == b_op[31]) && (sum33[31] != SrcA[31]);
      end
    end
  end

  // One multiply step; the last step's sum is also the final product.
  always_comb begin
    acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : 32'd0);
    mul_flags = {acc_step[31], (acc_step == 32'd0), Flags[1:0]};
  end

  // Control FSM, multiplier registers and the output/flags registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 5'd0;
      mcand_reg  <= 32'd0;
      mplier_reg <= 32'd0;
      acc_reg    <= 32'd0;
      s_reg      <= 1'b0;
      Result     <= 32'd0;
      Flags      <= 4'b0000;
      out_valid  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (Alu_Control == OP_MUL) begin
              state_reg  <= MUL;
              cnt_reg    <= 5'd0;
              mcand_reg  <= SrcA;
              mplier_reg <= SrcB;
              acc_reg    <= 32'd0;
              s_reg      <= S;
              // Accepting implies any pending result is drained on this edge.
              out_valid  <= 1'b0;
            end else begin
              Result    <= alu_res;
              Flags     <= alu_flags;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc_reg    <= acc_step;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd31) begin
            Result    <= acc_step;
            out_valid <= 1'b1;
            state_reg <= IDLE;
            if (s_reg) begin
              Flags <= mul_flags;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec. A monitor pushes bench-modelled
// results on every accept and pops/compares them on every output transfer;
// scenario tasks add their own cycle-level checks.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [2:0]  Alu_Control;
  logic        S;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic [3:0]  Flags;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic [2:0]  op;
  } exp_t;

  exp_t        sbq[$];
  logic [3:0]  mflags = 4'b0000;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -SMAX - 1;

  alu_exec dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .Alu_Control(Alu_Control),
    .S          (S),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .Flags      (Flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Monitor: samples mid-low-phase, after the drivers have settled.
  exp_t        me;
  logic [31:0] mr;
  logic        mc;
  logic        mv;
  logic [63:0] u64;
  longint      sd;

  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected result=%h flags=%b (no result outstanding)", Result, Flags);
        end else begin
          me = sbq.pop_front();
          if (Result !== me.r || Flags !== me.f) begin
            bad++;
            $display("FAIL sb_op%0d result=%h flags=%b want result=%h flags=%b",
                     me.op, Result, Flags, me.r, me.f);
          end else begin
            $display("xfer op=%0d result=%h flags=%b", me.op, Result, Flags);
          end
        end
      end
      if (in_valid && in_ready) begin
        mr = 32'd0;
        mc = mflags[1];
        mv = mflags[0];
        case (Alu_Control)
          3'd0: begin
            u64 = 64'(SrcA) + 64'(SrcB);
            mr  = u64[31:0];
            mc  = (u64 > 64'h00000000FFFFFFFF);
            sd  = longint'($signed(SrcA)) + longint'($signed(SrcB));
            mv  = (sd > SMAX) || (sd < SMIN);
          end
          3'd1: begin
            mr = SrcA - SrcB;
            mc = (SrcA >= SrcB);
            sd = longint'($signed(SrcA)) - longint'($signed(SrcB));
            mv = (sd > SMAX) || (sd < SMIN);
          end
          3'd2: mr = SrcA & SrcB;
          3'd3: mr = SrcA | SrcB;
          3'd4: mr = SrcB;
          3'd5: mr = SrcA ^ SrcB;
          3'd6: mr = SrcA & ~SrcB;
          default: begin
            u64 = 64'(SrcA) * 64'(SrcB);
            mr  = u64[31:0];
          end
        endcase
        if (S) begin
          if (Alu_Control == 3'd0 || Alu_Control == 3'd1)
            mflags = {mr[31], (mr == 32'd0), mc, mv};
          else
            mflags = {mr[31], (mr == 32'd0), mflags[1:0]};
        end
        sbq.push_back('{r: mr, f: mflags, op: Alu_Control});
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic s);
    in_valid    = v;
    Alu_Control = op;
    SrcA        = a;
    SrcB        = b;
    S           = s;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (Result !== 32'd0 || Flags !== 4'b0000) begin
      bad++;
      $display("FAIL reset_regs result=%h flags=%b want 00000000/0000", Result, Flags);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ctrl out_valid=%b busy=%b in_ready=%b want 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_first_add();
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || Result !== 32'h0 || Flags !== 4'b0110) begin
      bad++;
      $display("FAIL first_add out_valid=%b result=%h flags=%b want 1/00000000/0110", out_valid, Result, Flags);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_sub_eor();
    @(negedge clk);
    drive(1'b1, 3'd1, 32'h80000000, 32'h00000001, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || Result !== 32'h7FFFFFFF || Flags !== 4'b0011) begin
      bad++;
      $display("FAIL sub_ovf out_valid=%b result=%h flags=%b want 1/7fffffff/0011", out_valid, Result, Flags);
    end
    drive(1'b1, 3'd5, 32'h5, 32'h5, 1'b1);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || Result !== 32'h0 || Flags !== 4'b0111) begin
      bad++;
      $display("FAIL eor_keep_cv out_valid=%b result=%h flags=%b want 1/00000000/0111", out_valid, Result, Flags);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_mul();
    int errs;
    int waited;
    @(negedge clk);
    drive(1'b1, 3'd7, 32'h00010003, 32'h00000007, 1'b0);
    errs = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) errs++;
      // Junk on the input side must be ignored while multiplying.
      if (i < 25) drive(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'b1);
      else        drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mul_busy_window bad_cycles=%0d want 0", errs);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || Result !== 32'h00070015 || Flags !== 4'b0111) begin
      bad++;
      $display("FAIL mul_result out_valid=%b busy=%b result=%h flags=%b want 1/0/00070015/0111",
               out_valid, busy, Result, Flags);
    end
    // Second multiply with S=1 and wide operands; scoreboard checks the value.
    drive(1'b1, 3'd7, 32'h12345678, 32'h9ABCDEF1, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (waited != 32) begin
      bad++;
      $display("FAIL mul_latency cycles=%0d want 32", waited);
    end
  endtask

  task automatic test_backpressure();
    int errs;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 32'hF0F00000, 32'h0000F0F1, 1'b1);
    errs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Result !== 32'hF0F0F0F1 || out_valid !== 1'b1 || in_ready !== 1'b0) errs++;
      // A pending AND is offered but must wait for the drain.
      drive(1'b1, 3'd2, 32'hFF00FF00, 32'h0FF00FF0, 1'b1);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL bp_hold bad_cycles=%0d result=%h want 0 / f0f0f0f1", errs, Result);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || Result !== 32'h0F000F00) begin
      bad++;
      $display("FAIL bp_drain_accept out_valid=%b result=%h want 1/0f000f00", out_valid, Result);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mul();
    int stale;
    @(negedge clk);
    drive(1'b1, 3'd7, 32'd5, 32'd6, 1'b1);
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || Result !== 32'd0 || Flags !== 4'b0000 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_mul busy=%b out_valid=%b result=%h flags=%b in_ready=%b want 0/0/0/0000/1",
               busy, out_valid, Result, Flags, in_ready);
    end
    sbq.delete();
    mflags = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    total++;
    if (stale != 0) begin
      bad++;
      $display("FAIL reset_no_stale out_valid_cycles=%0d want 0", stale);
    end
    drive(1'b1, 3'd0, 32'd2, 32'd3, 1'b0);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || Result !== 32'd5) begin
      bad++;
      $display("FAIL add_after_reset out_valid=%b result=%h want 1/00000005", out_valid, Result);
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int errs;
    @(negedge clk);
    drive(1'b1, 3'd1, 32'd0, 32'd1, 1'b1);   // sets NZCV = 1000
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0 && (out_valid !== 1'b1 || Result !== (32'hDEADBEEF ^ 32'(i - 1)) || Flags !== 4'b1000))
        errs++;
      drive(1'b1, 3'd4, 32'h12345678, 32'hDEADBEEF ^ 32'(i), 1'b0);
    end
    @(negedge clk);
    if (out_valid !== 1'b1 || Result !== (32'hDEADBEEF ^ 32'd3) || Flags !== 4'b1000) errs++;
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mov_back_to_back bad_cycles=%0d flags=%b want 0 / 1000", errs, Flags);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    int waited;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd0;
      drive(1'($urandom_range(0, 1)), op, $urandom, $urandom, 1'($urandom_range(0, 1)));
      out_ready = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    out_ready = 1'b1;
    waited = 0;
    while ((sbq.size() != 0 || out_valid === 1'b1 || busy === 1'b1) && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    total++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_drain outstanding=%0d out_valid=%b want 0/0", sbq.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_add();
    test_sub_eor();
    test_mul();
    test_backpressure();
    test_reset_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
